mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port.
// - Sits between processor_pipe_top's IF/MEM stages and the memory; one outstanding transaction at a time.
// - Gives DM fixed priority, with a starvation guard for IF; a lost grant is the stage's stall condition.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and DM ports: DM has fixed priority, IF wins after STARVE_LIMIT lost arbitrations.
// Latency: grant in the request cycle, response routed through combinationally. Optional counters via ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_err
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]         stat_if_gnt,
  output logic [31:0]         stat_dm_gnt,
  output logic [31:0]         stat_stall
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_win, dm_win;

  assign if_win = if_req & ((starve_cnt == LIMIT) | ~dm_req);
  assign dm_win = dm_req & ~if_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (if_win)      state_nxt = BUSY_IF;
        else if (dm_win) state_nxt = BUSY_DM;
      end
      BUSY_IF, BUSY_DM: if (mem_rvalid) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (if_win) begin
          if_gnt   = 1'b1;
          mem_req  = 1'b1;
          mem_be   = '1;
          mem_addr = if_addr;
        end else if (dm_win) begin
          dm_gnt    = 1'b1;
          mem_req   = 1'b1;
          mem_we    = dm_we;
          mem_be    = dm_be;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
        end
      end
      BUSY_IF: if (mem_rvalid) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      BUSY_DM: if (mem_rvalid) begin
        dm_rvalid = 1'b1;
        dm_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

  // Grants only exist in IDLE, so the counter naturally holds while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      starve_cnt <= '0;
    else if (if_gnt)                                starve_cnt <= '0;
    else if (if_req && dm_gnt && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            arb_err <= 1'b0;
    else if (state == IDLE && mem_rvalid) arb_err <= 1'b1;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_if_gnt <= '0;
      stat_dm_gnt <= '0;
      stat_stall  <= '0;
    end else begin
      if (if_gnt) stat_if_gnt <= stat_if_gnt + 32'd1;
      if (dm_gnt) stat_dm_gnt <= stat_dm_gnt + 32'd1;
      if ((if_req & ~if_gnt) | (dm_req & ~dm_gnt)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions, expected events queued up front, a monitor pops them in order.
module tb_mem_port_arbiter;
  localparam int K_IG = 0, K_DG = 1, K_IR = 2, K_DR = 3;

  typedef struct {
    int          kind;
    int          gap;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be, mem_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_rvalid, arb_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mdl_rvalid, inj_rvalid;
  logic [31:0] mdl_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] stat_if_gnt, stat_dm_gnt, stat_stall;
`endif

  int   checks, failures, cyc, prev_cyc, lat;
  exp_t exp_q[$];

  assign mem_rvalid = mdl_rvalid | inj_rvalid;
  assign mem_rdata  = mdl_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .arb_err(arb_err)
`ifdef ARB_STATS_EN
    , .stat_if_gnt(stat_if_gnt), .stat_dm_gnt(stat_dm_gnt), .stat_stall(stat_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int g, input logic [31:0] a, input logic we,
                      input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.gap = g; e.addr = a; e.we = we; e.be = be; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_if(input logic [31:0] a);
    bit got = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_gnt) begin got = 1'b1; break; end
    end
    if (!got) begin checks++; failures++; $display("FAIL if_gnt_timeout: got none want grant"); end
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = '0;
  endtask

  task automatic drive_dm(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = a; dm_wdata = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dm_gnt) begin got = 1'b1; break; end
    end
    if (!got) begin checks++; failures++; $display("FAIL dm_gnt_timeout: got none want grant"); end
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   k, n;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        n = int'(if_gnt) + int'(dm_gnt) + int'(if_rvalid) + int'(dm_rvalid);
        chk("mem_req_vs_gnt", 32'(mem_req), 32'(if_gnt | dm_gnt));
        if (!if_rvalid) chk("if_rdata_quiet", if_rdata, 32'h0);
        if (!dm_rvalid) chk("dm_rdata_quiet", dm_rdata, 32'h0);
        if (n > 1) chk("strobe_count", 32'(n), 32'd1);
        else if (n == 1) begin
          k = if_gnt ? K_IG : dm_gnt ? K_DG : if_rvalid ? K_IR : K_DR;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event: got kind %0d want none", k);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            if (e.gap >= 0) chk("event_gap", 32'(cyc - prev_cyc), 32'(e.gap));
            prev_cyc = cyc;
            if (k == K_IG || k == K_DG) begin
              chk("mem_addr", mem_addr, e.addr);
              chk("mem_we", 32'(mem_we), 32'(e.we));
              chk("mem_be", 32'(mem_be), 32'(e.be));
              chk("mem_wdata", mem_wdata, (k == K_DG) ? e.data : 32'h0);
            end else begin
              chk("rdata", (k == K_IR) ? if_rdata : dm_rdata, e.data);
            end
          end
        end
      end
    end
  endtask

  // One response per captured request, lat cycles after the request cycle.
  task automatic mem_model();
    logic [31:0] a;
    logic        w;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        a = mem_addr; w = mem_we;
        repeat (lat) @(posedge clk);
        #1 mdl_rvalid = 1'b1; mdl_rdata = w ? 32'h0 : rd(a);
        @(posedge clk);
        #1 mdl_rvalid = 1'b0; mdl_rdata = '0;
      end
    end
  endtask

  task automatic run_tests();
    repeat (3) @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("rst_arb_err", 32'(arb_err), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Lone IF fetch
    push(K_IG, -1, 32'h10, 1'b0, 4'hF, 32'h0);
    push(K_IR, 1, 32'h0, 1'b0, 4'h0, 32'h0050_0093);
    drive_if(32'h10);
    drain();

    // DM partial write
    push(K_DG, -1, 32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    push(K_DR, 1, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_dm(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
    drain();

    // Simultaneous requests: DM first, IF right after DM completes
    push(K_DG, -1, 32'h40, 1'b0, 4'hF, 32'h0);
    push(K_DR, 1, 32'h0, 1'b0, 4'h0, 32'hC0DE_0040);
    push(K_IG, 1, 32'h80, 1'b0, 4'hF, 32'h0);
    push(K_IR, 1, 32'h0, 1'b0, 4'h0, 32'hC0DE_0080);
    fork
      drive_dm(1'b0, 4'hF, 32'h40, 32'h0);
      drive_if(32'h80);
    join
    drain();

    // Starvation: DM held high wins four times, then IF
    for (int i = 0; i < 4; i++) begin
      push(K_DG, (i == 0) ? -1 : 1, 32'h44, 1'b0, 4'hF, 32'h0);
      push(K_DR, 1, 32'h0, 1'b0, 4'h0, 32'hC0DE_0044);
    end
    push(K_IG, 1, 32'h84, 1'b0, 4'hF, 32'h0);
    push(K_IR, 1, 32'h0, 1'b0, 4'h0, 32'hC0DE_0084);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h44; dm_wdata = '0;
    if_req = 1'b1; if_addr = 32'h84;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_gnt) break;
    end
    @(posedge clk); #1;
    dm_req = 1'b0; dm_be = '0; dm_addr = '0; if_req = 1'b0; if_addr = '0;
    drain();

    // Counter cleared by the IF grant: contention goes to DM again
    push(K_DG, -1, 32'h48, 1'b0, 4'hF, 32'h0);
    push(K_DR, 1, 32'h0, 1'b0, 4'h0, 32'hC0DE_0048);
    push(K_IG, 1, 32'h88, 1'b0, 4'hF, 32'h0);
    push(K_IR, 1, 32'h0, 1'b0, 4'h0, 32'hC0DE_0088);
    fork
      drive_dm(1'b0, 4'hF, 32'h48, 32'h0);
      drive_if(32'h88);
    join
    drain();

    // Slow memory; an IF request raised and dropped while busy is never granted
    lat = 3;
    push(K_DG, -1, 32'h4C, 1'b0, 4'hF, 32'h0);
    push(K_DR, 3, 32'h0, 1'b0, 4'h0, 32'hC0DE_004C);
    fork
      drive_dm(1'b0, 4'hF, 32'h4C, 32'h0);
      begin
        @(posedge clk); @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h90;
        @(posedge clk); #1 if_req = 1'b0; if_addr = '0;
      end
    join
    drain();
    lat = 1;

    // Stray completion while idle
    @(posedge clk); #1 inj_rvalid = 1'b1;
    @(negedge clk); chk("arb_err_before", 32'(arb_err), 32'h0);
    @(posedge clk); #1 inj_rvalid = 1'b0;
    @(negedge clk); chk("arb_err_set", 32'(arb_err), 32'h1);
    repeat (3) @(negedge clk);
    chk("arb_err_sticky", 32'(arb_err), 32'h1);

    // Reset while DM transaction is outstanding
    lat = 3;
    push(K_DG, -1, 32'h300, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h300;
    @(posedge clk); #1;
    dm_req = 1'b0; dm_be = '0; dm_addr = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("arb_err_after_rst", 32'(arb_err), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("dropped_rvalid", 32'(dm_rvalid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("arb_err_late_rvalid", 32'(arb_err), 32'h1);
    lat = 1;
    push(K_IG, -1, 32'h10, 1'b0, 4'hF, 32'h0);
    push(K_IR, 1, 32'h0, 1'b0, 4'h0, 32'h0050_0093);
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk); chk("idle_after_rst_gnt", 32'(if_gnt), 32'h1);
    @(posedge clk); #1 if_req = 1'b0; if_addr = '0;
    drain();

`ifdef ARB_STATS_EN
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(K_IG, -1, 32'h10 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
      push(K_IR, 1, 32'h0, 1'b0, 4'h0, (i == 0) ? 32'h0050_0093 : (32'hC0DE_0010 + 32'(4 * i)));
      drive_if(32'h10 + 32'(4 * i));
      drain();
    end
    for (int i = 0; i < 2; i++) begin
      push(K_DG, -1, 32'h400, 1'b1, 4'hF, 32'h1234_5678);
      push(K_DR, 1, 32'h0, 1'b0, 4'h0, 32'h0);
      drive_dm(1'b1, 4'hF, 32'h400, 32'h1234_5678);
      drain();
    end
    chk("stat_if_gnt", stat_if_gnt, 32'd3);
    chk("stat_dm_gnt", stat_dm_gnt, 32'd2);
    chk("stat_stall", stat_stall, 32'd0);
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; prev_cyc = 0; lat = 1;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mdl_rvalid = 1'b0; mdl_rdata = '0; inj_rvalid = 1'b0;
    fork
      monitor();
      mem_model();
      run_tests();
      begin
        #100000;
        checks++; failures++;
        $display("FAIL watchdog: got timeout want completion");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
